fetch_unit: RTL

Instruction fetch stage sitting directly upstream of the instruction decoder; supplies the 32-bit op_value the decoder consumes.
- Holds the fetch PC and issues word requests to instruction memory.
- Buffers returned instructions in a small in-order FIFO.
- Presents them to the decoder with a valid/ready handshake.
- Handles redirects (taken branch/jump, pcsrc true) by flushing the FIFO and discarding in-flight stale responses.

---
 rtl/fetch_unit_if.sv | 37 +++
 rtl/fetch_unit.sv | 130 +++++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response, redirect and decoder handshake.
// FETCH_STATS_EN adds the stat_fetched/stat_dropped counters.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        op_valid;
  logic [31:0] op_value;
  logic [31:0] op_pc;
  logic        op_ready;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_dropped;

  modport master (
    output imem_req, imem_addr, op_valid, op_value, op_pc, stat_fetched, stat_dropped,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, op_ready
  );
  modport slave (
    input  imem_req, imem_addr, op_valid, op_value, op_pc, stat_fetched, stat_dropped,
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, op_ready
  );
`else
  modport master (
    output imem_req, imem_addr, op_valid, op_value, op_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, op_ready
  );
  modport slave (
    input  imem_req, imem_addr, op_valid, op_value, op_pc,
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, op_ready
  );
`endif
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited word requests, in-order response FIFO, redirect flush.
// Optional macro FETCH_STATS_EN enables fetched/dropped counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   op_value_q, op_value_d;
  logic [31:0]   op_pc_q, op_pc_d;
  logic [31:0]   mem_data [BUF_DEPTH];
  logic [31:0]   mem_pc   [BUF_DEPTH];
  logic [31:0]   target_pc;
  logic          credit_ok, req, fire, discard, push, pop, op_valid;

  assign target_pc = bus.redirect_pc & 32'hFFFF_FFFC;
  // inflight counts every outstanding request, stale or not, so a response always finds a slot
  assign credit_ok = ({1'b0, count_q} + {1'b0, inflight_q}) < (CW+1)'(BUF_DEPTH);
  assign req       = !rst && !bus.redirect && credit_ok;
  assign fire      = req && bus.imem_gnt;
  assign discard   = bus.imem_rvalid && (bus.redirect || (drop_cnt_q != '0));
  assign push      = bus.imem_rvalid && !discard;
  assign op_valid  = (count_q != '0);
  assign pop       = op_valid && bus.op_ready;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = inflight_q + CW'(fire) - CW'(bus.imem_rvalid);
    drop_cnt_d = drop_cnt_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    op_value_d = op_value_q;
    op_pc_d    = op_pc_q;
    if (bus.redirect) begin
      fetch_pc_d = target_pc;
      resp_pc_d  = target_pc;
      // everything still outstanding after this edge belongs to the old path
      drop_cnt_d = inflight_q - CW'(bus.imem_rvalid);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (push) resp_pc_d = resp_pc_q + 32'd4;
      drop_cnt_d = drop_cnt_q - CW'(discard);
      count_d    = count_q + CW'(push) - CW'(pop);
      rd_ptr_d   = rd_ptr_q + PW'(pop);
      wr_ptr_d   = wr_ptr_q + PW'(push);
      // preload the output register with whatever will be at the head after this edge
      if (count_d != '0) begin
        if (push && (wr_ptr_q == rd_ptr_d)) begin
          op_value_d = bus.imem_rdata;
          op_pc_d    = resp_pc_q;
        end else begin
          op_value_d = mem_data[rd_ptr_d];
          op_pc_d    = mem_pc[rd_ptr_d];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      drop_cnt_q <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      op_value_q <= NOP;
      op_pc_q    <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      op_value_q <= op_value_d;
      op_pc_q    <= op_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_data[wr_ptr_q] <= bus.imem_rdata;
      mem_pc[wr_ptr_q]   <= resp_pc_q;
    end
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = fetch_pc_q;
  assign bus.op_valid  = op_valid;
  assign bus.op_value  = op_value_q;
  assign bus.op_pc     = op_pc_q;

`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched_q, stat_dropped_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_fetched_q <= '0;
      stat_dropped_q <= '0;
    end else begin
      if (pop && (stat_fetched_q != 32'hFFFF_FFFF)) stat_fetched_q <= stat_fetched_q + 32'd1;
      if (discard && (stat_dropped_q != 32'hFFFF_FFFF)) stat_dropped_q <= stat_dropped_q + 32'd1;
    end
  end

  assign bus.stat_fetched = stat_fetched_q;
  assign bus.stat_dropped = stat_dropped_q;
`endif
endmodule
